// File: rtl/unpack_pkg.sv
// Shared types and helpers for the unpacker packet scheduler and its arbiter.
package unpack_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StHdr  = 2'b01,
    StData = 2'b10,
    StDone = 2'b11
  } state_e;

  // Length field sits at the bottom of the header beat.
  localparam int unsigned LenLsb  = 0;
  localparam int unsigned DefLenW = 16;

  localparam int unsigned MaxReq = 8;

  // First set bit of req strictly after ptr, circularly over n requesters.
  function automatic int unsigned rr_pick(logic [MaxReq-1:0] req, int unsigned ptr,
                                          int unsigned n);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      idx = (ptr + k) % n;
      if (k <= n && !found && ((req >> idx) & MaxReq'(1)) != '0) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker with a pointer register; the pointer moves only on an update strobe.
module rr_arbiter import unpack_pkg::*; #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       update,
  input  logic [$clog2(NUM_REQ)-1:0] update_idx,
  output logic [$clog2(NUM_REQ)-1:0] pick,
  output logic                       any
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [IdW-1:0] ptr_q;

  // Reset to the last index so that source 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IdW'(NUM_REQ - 1);
    end else if (update) begin
      ptr_q <= update_idx;
    end
  end

  assign any  = |req;
  assign pick = IdW'(rr_pick(MaxReq'(req), 32'(ptr_q), NUM_REQ));

endmodule

// File: rtl/unpack_sched.sv
// Packet-granular round-robin scheduler feeding one unpacker from NUM_REQ frame sources.
module unpack_sched import unpack_pkg::*; #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned DATAWIDTH = 512,
  parameter int unsigned LEN_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATAWIDTH-1:0]           out_data,
  output logic                           out_valid,
  output logic                           out_inst,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           pkt_done
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [IdW-1:0]       grant_q, grant_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] sel_data;
  logic                 sel_valid;
  logic [LEN_W-1:0]     hdr_len;
  logic [IdW-1:0]       arb_pick;
  logic                 arb_any;
  logic                 arb_update;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req_valid),
    .update     (arb_update),
    .update_idx (grant_q),
    .pick       (arb_pick),
    .any        (arb_any)
  );

  assign sel_data  = req_data[32'(grant_q) * DATAWIDTH +: DATAWIDTH];
  assign sel_valid = req_valid[grant_q];
  assign hdr_len   = sel_data[LenLsb +: LEN_W];
  assign grant_id  = rst ? '0 : grant_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    out_data   = '0;
    out_valid  = 1'b0;
    out_inst   = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    pkt_done   = 1'b0;
    arb_update = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          grant_d = arb_pick;
          state_d = StHdr;
        end
      end
      StHdr: begin
        busy               = 1'b1;
        out_inst           = 1'b1;
        out_last           = (hdr_len == '0);
        out_valid          = sel_valid;
        out_data           = sel_data;
        req_ready[grant_q] = out_ready;
        if (sel_valid && out_ready) begin
          cnt_d   = hdr_len;
          state_d = (hdr_len == '0) ? StDone : StData;
        end
      end
      StData: begin
        busy               = 1'b1;
        out_last           = (cnt_q == LEN_W'(1));
        out_valid          = sel_valid;
        out_data           = sel_data;
        req_ready[grant_q] = out_ready;
        if (sel_valid && out_ready) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        pkt_done   = 1'b1;
        arb_update = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reset is synchronous, so the outputs must be forced quiet for the whole reset cycle.
    if (rst) begin
      req_ready  = '0;
      out_data   = '0;
      out_valid  = 1'b0;
      out_inst   = 1'b0;
      out_last   = 1'b0;
      busy       = 1'b0;
      pkt_done   = 1'b0;
      arb_update = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_unpack_sched.sv
// Randomised bench for unpack_sched with a transaction-level packet/round-robin model.
module tb_unpack_sched;

  localparam int NumReq = 3;
  localparam int Dw     = 512;
  localparam int LenW   = 8;
  localparam int IdW    = 2;
  localparam int MaxPkt = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NumReq*Dw-1:0] req_data;
  logic [NumReq-1:0]    req_valid;
  logic [NumReq-1:0]    req_ready;
  logic [Dw-1:0]        out_data;
  logic                 out_valid, out_inst, out_last, out_ready;
  logic [IdW-1:0]       grant_id;
  logic                 busy, pkt_done;

  always #5 clk = ~clk;

  unpack_sched #(
    .NUM_REQ   (NumReq),
    .DATAWIDTH (Dw),
    .LEN_W     (LenW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .pkt_done  (pkt_done)
  );

  int tests = 0;
  int fails = 0;

  // Stimulus configuration.
  bit go [NumReq];
  int n_pkt [NumReq];
  int len_tab [NumReq][MaxPkt+1];
  int drop_pct = 0;
  int ready_pct = 100;
  int stall_at = -1;
  int drop_left [NumReq];

  // Source-side progress and handshakes seen at the last sample point.
  int pk [NumReq];
  int bt [NumReq];
  logic [NumReq-1:0] xfer = '0;

  // Model state.
  bit m_in = 0, m_done = 0;
  int m_ptr = NumReq - 1, m_owner = 0, m_pos = 0, m_len = 0;
  int m_cnt [NumReq];

  // Observations of the DUT.
  int cyc = 0, beats_seen = 0, dones_seen = 0, stall_seen = 0;
  int grant_log[$];
  int hdr_cyc[$];

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_data(logic [Dw-1:0] act, logic [Dw-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL out_data: got %0h expected %0h", act, exp);
    end
  endtask

  function automatic logic [Dw-1:0] make_beat(int s, int k, int b, int len);
    logic [Dw-1:0] r;
    for (int w = 0; w < Dw / 32; w++) r[w*32 +: 32] = 32'(s * 1000003 + k * 7919 + b * 131 + w * 17 + 5);
    if (b == 0) r[LenW-1:0] = LenW'(len);
    return r;
  endfunction

  function automatic bit all_sent();
    for (int i = 0; i < NumReq; i++) if (go[i] && pk[i] < n_pkt[i]) return 1'b0;
    return !m_in && !m_done;
  endfunction

  function automatic longint grants_packed();
    longint g = 0;
    foreach (grant_log[i]) g = g | (longint'(grant_log[i]) << (4 * i));
    return g;
  endfunction

  // Source and sink drivers.
  int stall_left = 0;
  initial begin
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NumReq; i++) begin
        if (rst) begin
          pk[i] = 0; bt[i] = 0; drop_left[i] = 0;
        end else if (xfer[i]) begin
          bt[i]++;
          if (bt[i] > len_tab[i][pk[i]]) begin bt[i] = 0; pk[i]++; end
        end
        if (drop_left[i] > 0) begin
          req_valid[i] = 1'b0;
          drop_left[i]--;
        end else begin
          req_valid[i] = go[i] && pk[i] < n_pkt[i] && ($urandom_range(99) >= drop_pct);
        end
        req_data[i*Dw +: Dw] = make_beat(i, pk[i], bt[i], len_tab[i][pk[i]]);
      end
      if (rst) stall_left = 0;
      else if (stall_at >= 0 && m_in && m_pos == stall_at) begin stall_left = 5; stall_at = -1; end
      if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
      else out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Compare process: outputs against the packet-level model on every cycle.
  initial begin
    logic [NumReq-1:0] e_ready;
    bit e_valid;
    forever begin
      @(negedge clk);
      cyc++;
      xfer = req_valid & req_ready;
      if (rst) begin
        chk("reset_outputs", {req_ready, out_valid, out_inst, out_last, busy, pkt_done}, 0);
        m_in = 0; m_done = 0; m_ptr = NumReq - 1; m_owner = 0; m_pos = 0;
        for (int i = 0; i < NumReq; i++) m_cnt[i] = 0;
      end else begin
        e_valid = m_in && req_valid[m_owner];
        e_ready = '0;
        if (m_in) e_ready[m_owner] = out_ready;
        chk("busy", busy, m_in);
        chk("pkt_done", pkt_done, m_done);
        chk("req_ready", req_ready, e_ready);
        chk("out_valid", out_valid, e_valid);
        if (m_in) chk("grant_id", grant_id, m_owner);
        if (e_valid) begin
          m_len = len_tab[m_owner][m_cnt[m_owner]];
          chk("out_inst", out_inst, m_pos == 0);
          chk("out_last", out_last, m_pos == m_len);
          chk_data(out_data, make_beat(m_owner, m_cnt[m_owner], m_pos, m_len));
        end
        if (out_valid && out_ready) begin
          beats_seen++;
          if (out_inst) begin grant_log.push_back(int'(grant_id)); hdr_cyc.push_back(cyc); end
        end
        if (out_valid && !out_ready) stall_seen++;
        if (pkt_done) dones_seen++;
        // Packet lifecycle: beats, one done cycle, one arbitration cycle.
        if (m_done) begin
          m_done = 0;
          m_ptr  = m_owner;
        end else if (m_in) begin
          if (e_valid && out_ready) begin
            m_pos++;
            if (m_pos > m_len) begin m_in = 0; m_done = 1; m_cnt[m_owner]++; end
          end
        end else if (req_valid != '0) begin
          for (int k = NumReq; k >= 1; k--)
            if (req_valid[(m_ptr + k) % NumReq]) m_owner = (m_ptr + k) % NumReq;
          m_in  = 1;
          m_pos = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < NumReq; i++) begin
      go[i] = 0; n_pkt[i] = 0;
      for (int k = 0; k <= MaxPkt; k++) len_tab[i][k] = 0;
    end
    drop_pct = 0; ready_pct = 100; stall_at = -1;
  endtask

  task automatic clear_stats();
    beats_seen = 0; dones_seen = 0; stall_seen = 0;
    grant_log.delete();
    hdr_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_stats();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(string nm, int budget);
    bit ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      ok = all_sent();
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_pos(string nm, int owner, int pos, int budget);
    bit ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      ok = m_in && m_owner == owner && m_pos == pos;
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_cfg();
    step();

    // Single source, LEN=3, two packets back to back.
    clear_cfg();
    go[0] = 1; n_pkt[0] = 2; len_tab[0][0] = 3; len_tab[0][1] = 3;
    do_reset();
    wait_idle("t1_timeout", 200);
    chk("t1_beats", beats_seen, 8);
    chk("t1_dones", dones_seen, 2);
    chk("t1_grants", grants_packed(), 'h00);
    chk("t1_period", hdr_cyc.size() == 2 ? hdr_cyc[1] - hdr_cyc[0] : -1, 6);

    // Two sources re-requesting, LEN=2 each.
    clear_cfg();
    for (int i = 0; i < 2; i++) begin
      go[i] = 1; n_pkt[i] = 2; len_tab[i][0] = 2; len_tab[i][1] = 2;
    end
    do_reset();
    wait_idle("t2_timeout", 200);
    chk("t2_ngrants", grant_log.size(), 4);
    chk("t2_order", grants_packed(), 'h1010);
    chk("t2_beats", beats_seen, 12);

    // LEN=0 header on source 1.
    clear_cfg();
    go[1] = 1; n_pkt[1] = 1; len_tab[1][0] = 0;
    do_reset();
    wait_idle("t3_timeout", 100);
    chk("t3_beats", beats_seen, 1);
    chk("t3_dones", dones_seen, 1);
    chk("t3_grants", grants_packed(), 'h1);

    // Sink stall of 5 cycles on beat 2 of a LEN=4 packet.
    clear_cfg();
    go[0] = 1; n_pkt[0] = 1; len_tab[0][0] = 4; stall_at = 2;
    do_reset();
    wait_idle("t4_timeout", 100);
    chk("t4_beats", beats_seen, 5);
    chk("t4_stall", stall_seen, 5);

    // Source 0 goes quiet mid-packet while source 1 waits.
    clear_cfg();
    go[0] = 1; n_pkt[0] = 1; len_tab[0][0] = 4;
    go[1] = 1; n_pkt[1] = 1; len_tab[1][0] = 1;
    do_reset();
    wait_pos("t5_reach", 0, 2, 50);
    drop_left[0] = 3;
    wait_idle("t5_timeout", 100);
    chk("t5_grants", grants_packed(), 'h10);
    chk("t5_beats", beats_seen, 7);

    // Reset in the middle of a LEN=7 packet with 5 data beats left.
    clear_cfg();
    go[0] = 1; n_pkt[0] = 1; len_tab[0][0] = 7;
    do_reset();
    wait_pos("t6_reach", 0, 3, 50);
    rst = 1'b1;
    go[0] = 0;
    go[1] = 1; n_pkt[1] = 1; len_tab[1][0] = 2;
    clear_stats();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_done_after_rst", pkt_done, 0);
    wait_idle("t6_timeout", 100);
    chk("t6_grants", grants_packed(), 'h1);
    chk("t6_dones", dones_seen, 1);
    chk("t6_beats", beats_seen, 3);

    // Random traffic on all sources including a maximum-length packet.
    clear_cfg();
    for (int i = 0; i < NumReq; i++) begin
      go[i] = 1; n_pkt[i] = 8;
      for (int k = 0; k < 8; k++) len_tab[i][k] = $urandom_range(6);
    end
    len_tab[2][3] = (1 << LenW) - 1;
    drop_pct = 20; ready_pct = 70;
    do_reset();
    wait_idle("t7_timeout", 8000);
    chk("t7_dones", dones_seen, 3 * 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unpack_sched.md
Name: unpack_sched

Overview:
- Round-robin packet scheduler that shares one unpacker frame datapath between NUM_REQ frame sources.
- Each source sends packets on a valid/ready stream. Beat 0 is the instruction header; it is followed by LEN data beats, where LEN is carried in the header.
- The block grants one whole packet at a time, forwards its beats downstream with instruction/last tags, and pulses a per-packet done.
- It sits between the host frame sources and the unpacker input.

Parameters:
- NUM_REQ, 2, number of requesting sources; legal values 2..8.
- DATAWIDTH, 512, beat width in bits.
- LEN_W, 16, width of the length field, located in header bits [LEN_W-1:0].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_data  in  NUM_REQ*DATAWIDTH  source beats; source i occupies slice [i*DATAWIDTH +: DATAWIDTH].
- req_valid  in  NUM_REQ  per-source beat valid.
- req_ready  out  NUM_REQ  per-source beat accept.
- out_data  out  DATAWIDTH  beat forwarded to the unpacker.
- out_valid  out  1  forwarded beat valid.
- out_inst  out  1  high on the header beat.
- out_last  out  1  high on the final beat of a packet.
- out_ready  in  1  unpacker accept.
- grant_id  out  $clog2(NUM_REQ)  index of the source that owns the current packet.
- busy  out  1  high while a packet is in flight.
- pkt_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Clock and reset:
  - Single clock, clk. Reset rst is synchronous and active-high.
  - Reset values: state=IDLE, rr_ptr=NUM_REQ-1, grant_id=0, beat counter=0.
  - All outputs are 0 during reset: req_ready=0, out_valid=0, out_inst=0, out_last=0, busy=0, pkt_done=0.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - Forwarding is combinational in the HDR and DATA states (zero latency):
    - out_data = req_data[grant_id]
    - out_valid = req_valid[grant_id]
    - req_ready[grant_id] = out_ready
  - req_ready of every non-granted source is 0.
  - Once out_valid is asserted, out_data, out_inst and out_last hold until the beat transfers.
- FSM, state IDLE:
  - If any req_valid is high, pick the first requester strictly after rr_ptr in circular order.
  - Register it as grant_id and go to HDR.
  - No beat is forwarded in IDLE, so arbitration costs one bubble cycle.
- FSM, state HDR:
  - busy=1, out_inst=1.
  - On transfer, latch cnt = header[LEN_W-1:0].
  - If LEN==0: out_last=1 on the header beat, then go to DONE.
  - Otherwise go to DATA.
- FSM, state DATA:
  - busy=1, out_inst=0, out_last=(cnt==1).
  - Decrement cnt on each transfer; go to DONE when the transfer with cnt==1 completes.
- FSM, state DONE:
  - pkt_done=1 for exactly one cycle, busy=0.
  - rr_ptr <= grant_id, then go to IDLE.
- Fairness:
  - A source that requests again immediately waits behind every other pending requester.
  - With a single active source, consecutive packets are accepted every LEN+3 cycles.
- Boundary conditions:
  - A source deasserting req_valid mid-packet: out_valid drops and the FSM stalls in place. The grant is never revoked and there is no timeout.
  - Changes on non-granted sources' req_valid mid-packet are ignored.
  - out_ready held low stalls the packet with no beat lost or duplicated.
  - Simultaneous requests from all sources are served in order rr_ptr+1, rr_ptr+2, ... with wrap-around modulo NUM_REQ.
  - LEN = 2^LEN_W-1 is legal; the counter must not overflow.
  - rst asserted mid-packet: immediately return to IDLE with the reset values above. The partial packet is abandoned, with no pkt_done and no flush.
  - After reset, with all sources requesting, source 0 is granted first.

Decomposition:
- Shared package unpack_pkg:
  - State encoding: IDLE=2'b00, HDR=2'b01, DATA=2'b10, DONE=2'b11.
  - LEN field position constants.
  - Function rr_pick(req, ptr), returning the next index.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - Combinational pick from request vector and pointer.
  - Pointer register updated by an update strobe.
  - Reused by later shared-resource controllers.
- FSM, beat counter and mux remain in unpack_sched.

Test Plan:
1. Single source 0, header LEN=3, 3 data beats, out_ready=1:
   - 4 beats out; out_inst on beat 0 only; out_last on beat 3.
   - pkt_done pulses 1 cycle after beat 3; grant_id=0.
2. Sources 0 and 1 valid from reset, each LEN=2, continuously re-requesting:
   - Grant order 0,1,0,1.
   - No interleaving of beats within a packet.
3. Header LEN=0 on source 1:
   - Single beat with out_inst=1 and out_last=1; DONE follows; pkt_done=1.
4. out_ready low for 5 cycles on data beat 2 of LEN=4:
   - out_data stable throughout; exactly 5 beats delivered in order.
   - Source req_ready is low during the stall.
5. Source 0 drops req_valid for 3 cycles mid-packet while source 1 requests:
   - Grant stays 0 and the packet completes; source 1 is served next.
6. rst pulsed during DATA with cnt=5:
   - Next cycle: IDLE, busy=0, no pkt_done.
   - New packet from source 1 completes normally.
